ds18b20_slave: RTL and testbench

Behavioural 1-Wire responder that emulates a single DS18B20 on the `dq` line. The bench and loopback builds use it as the far end of the temperature-sensor master, so the master can be exercised without a physical sensor. It answers reset pulses with a presence pulse and decodes Skip ROM plus the Convert T and Read Scratchpad commands. It returns a 9-byte scratchpad, including a Dallas CRC8, built from a host-supplied temperature word.

---
 rtl/ds18b20_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_ds18b20_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_slave.sv
// Behavioural single-drop DS18B20 responder on an open-drain 1-Wire bus.
// Answers bus resets with presence, decodes Skip ROM, Convert T and Read Scratchpad.
module ds18b20_slave #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned CONV_US    = 750000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    inout  wire         dq,
    input  logic [15:0] temp_in,
    output logic        conv_done,
    output logic        cmd_err
);

    localparam int unsigned PreW  = $clog2(CLK_PER_US + 1);
    localparam int unsigned TmrW  = $clog2(120 * CLK_PER_US + 1);
    localparam int unsigned ConvW = $clog2(CONV_US + 1);

    // Timer compares are trimmed so that bus-visible events line up with dq_s,
    // which trails the pad by two cycles.
    localparam logic [TmrW-1:0] TPresWait = TmrW'(30 * CLK_PER_US - 2);
    localparam logic [TmrW-1:0] TPres     = TmrW'(120 * CLK_PER_US);
    localparam logic [TmrW-1:0] TSample   = TmrW'(30 * CLK_PER_US - 1);
    localparam logic [TmrW-1:0] TDrive0   = TmrW'(45 * CLK_PER_US - 3);

    typedef enum logic [2:0] {
        StIdle, StPresWait, StPres, StRomCmd, StFuncCmd, StConvert, StConvIdle, StTx
    } state_e;

    state_e            state_q, state_d;
    logic              dq_meta, dq_s, dq_prev;
    logic [PreW-1:0]   pre_q;
    logic [9:0]        low_us_q;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              rx_act_q, rx_act_d;
    logic [7:0]        sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              drv_q, drv_d;
    logic [TmrW-1:0]   drv_cnt_q, drv_cnt_d;
    logic [ConvW-1:0]  conv_q, conv_d;
    logic [15:0]       temp_reg_q, temp_reg_d;
    logic [7:0]        crc_q, crc_d;
    logic [3:0]        tx_byte_q, tx_byte_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic              conv_done_q, conv_done_d;
    logic              cmd_err_q, cmd_err_d;

    logic              us_tick, fall, rise, bus_reset;
    logic [7:0]        rx_byte, cur_byte;
    logic              tx_bit_val;

    assign dq        = drv_q ? 1'b0 : 1'bz;
    assign conv_done = conv_done_q;
    assign cmd_err   = cmd_err_q;

    // Own drive must not look like a master slot start.
    assign fall      = dq_prev & ~dq_s & ~drv_q;
    assign rise      = ~dq_prev & dq_s;
    assign us_tick   = (pre_q == PreW'(CLK_PER_US - 1));
    assign bus_reset = rise && (low_us_q >= 10'd480);
    assign rx_byte   = {dq_s, sr_q[7:1]};

    always_comb begin
        unique case (tx_byte_q)
            4'd0:    cur_byte = temp_reg_q[7:0];
            4'd1:    cur_byte = temp_reg_q[15:8];
            4'd2:    cur_byte = 8'h4B;
            4'd3:    cur_byte = 8'h46;
            4'd4:    cur_byte = 8'h7F;
            4'd5:    cur_byte = 8'hFF;
            4'd6:    cur_byte = 8'h0C;
            4'd7:    cur_byte = 8'h10;
            default: cur_byte = crc_q;
        endcase
    end
    assign tx_bit_val = cur_byte[tx_bit_q];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_meta  <= 1'b1;
            dq_s     <= 1'b1;
            dq_prev  <= 1'b1;
            pre_q    <= '0;
            low_us_q <= '0;
        end else begin
            dq_meta <= dq;
            dq_s    <= dq_meta;
            dq_prev <= dq_s;
            if ((dq_s != dq_prev) || us_tick) pre_q <= '0;
            else                              pre_q <= pre_q + 1'b1;
            if (dq_s)                                   low_us_q <= '0;
            else if (us_tick && (low_us_q != 10'd1023)) low_us_q <= low_us_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        rx_act_d    = rx_act_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        drv_d       = drv_q;
        drv_cnt_d   = drv_cnt_q;
        conv_d      = conv_q;
        temp_reg_d  = temp_reg_q;
        crc_d       = crc_q;
        tx_byte_d   = tx_byte_q;
        tx_bit_d    = tx_bit_q;
        conv_done_d = 1'b0;
        cmd_err_d   = 1'b0;

        if (drv_q) begin
            drv_cnt_d = drv_cnt_q - 1'b1;
            if (drv_cnt_q == TmrW'(1)) drv_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StConvIdle: begin
            end
            StPresWait: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TPresWait) begin
                    state_d   = StPres;
                    drv_d     = 1'b1;
                    drv_cnt_d = TPres;
                end
            end
            StPres: begin
                if (drv_q && (drv_cnt_q == TmrW'(1))) begin
                    state_d   = StRomCmd;
                    rx_act_d  = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            StRomCmd, StFuncCmd: begin
                if (fall) begin
                    rx_act_d = 1'b1;
                    tmr_d    = '0;
                end else if (rx_act_q) begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_q == TSample) begin
                        rx_act_d  = 1'b0;
                        sr_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StRomCmd) begin
                                if (rx_byte == 8'hCC) begin
                                    state_d = StFuncCmd;
                                end else begin
                                    cmd_err_d = 1'b1;
                                    state_d   = StIdle;
                                end
                            end else if (rx_byte == 8'h44) begin
                                state_d = StConvert;
                                conv_d  = '0;
                            end else if (rx_byte == 8'hBE) begin
                                state_d   = StTx;
                                tx_byte_d = '0;
                                tx_bit_d  = '0;
                                crc_d     = '0;
                            end else begin
                                cmd_err_d = 1'b1;
                                state_d   = StIdle;
                            end
                        end
                    end
                end
            end
            StConvert: begin
                // Busy: every read slot is answered with a 0.
                if (fall) begin
                    drv_d     = 1'b1;
                    drv_cnt_d = TDrive0;
                end
                if (us_tick) begin
                    conv_d = conv_q + 1'b1;
                    if (conv_q == ConvW'(CONV_US - 1)) begin
                        temp_reg_d  = temp_in;
                        conv_done_d = 1'b1;
                        state_d     = StConvIdle;
                    end
                end
            end
            StTx: begin
                if (fall) begin
                    if (!tx_bit_val) begin
                        drv_d     = 1'b1;
                        drv_cnt_d = TDrive0;
                    end
                    if (tx_byte_q != 4'd8) begin
                        crc_d = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ tx_bit_val) ? 8'h8C : 8'h00);
                    end
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) begin
                        tx_byte_d = tx_byte_q + 1'b1;
                        if (tx_byte_q == 4'd8) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus_reset) begin
            state_d   = StPresWait;
            tmr_d     = '0;
            rx_act_d  = 1'b0;
            bit_cnt_d = '0;
            drv_d     = 1'b0;
            drv_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            rx_act_q    <= 1'b0;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            drv_q       <= 1'b0;
            drv_cnt_q   <= '0;
            conv_q      <= '0;
            temp_reg_q  <= 16'h0550;
            crc_q       <= '0;
            tx_byte_q   <= '0;
            tx_bit_q    <= '0;
            conv_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rx_act_q    <= rx_act_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            drv_q       <= drv_d;
            drv_cnt_q   <= drv_cnt_d;
            conv_q      <= conv_d;
            temp_reg_q  <= temp_reg_d;
            crc_q       <= crc_d;
            tx_byte_q   <= tx_byte_d;
            tx_bit_q    <= tx_bit_d;
            conv_done_q <= conv_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_ds18b20_slave.sv
// Directed bench: a behavioural 1-Wire master drives the responder and a byte
// scoreboard checks every value read back.
`timescale 1ns/1ps
module tb_ds18b20_slave;

    localparam int unsigned C  = 2;     // clocks per us
    localparam int unsigned CV = 200;   // conversion time, us
    localparam int          US = 20;    // ns per us at 10 ns clock

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] temp_in = 16'h0000;
    logic        conv_done, cmd_err;
    logic        m_low = 1'b0;
    wire         dq;

    assign dq = m_low ? 1'b0 : 1'bz;
    pullup (dq);

    ds18b20_slave #(.CLK_PER_US(C), .CONV_US(CV)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .dq        (dq),
        .temp_in   (temp_in),
        .conv_done (conv_done),
        .cmd_err   (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks = 0;
    int         failures = 0;
    int         conv_done_cnt = 0;
    int         cmd_err_cnt = 0;
    longint     conv_done_t = 0;
    logic [7:0] exp_q[$];

    always @(posedge sys_clk) begin
        if (conv_done) begin
            conv_done_cnt <= conv_done_cnt + 1;
            conv_done_t   <= $time;
        end
        if (cmd_err) cmd_err_cnt <= cmd_err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[7:1]};
            if (fb) r = r ^ 8'h8C;
        end
        return r;
    endfunction

    task automatic write_bit(input logic b);
        m_low = 1'b1;
        #((b ? 2 : 60) * US);
        m_low = 1'b0;
        #((b ? 63 : 5) * US);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b1;
        #(2 * US);
        m_low = 1'b0;
        #(11 * US);
        b = dq;
        #(37 * US);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    // Pop-and-compare against the scoreboard.
    task automatic read_check(input string tag);
        logic [7:0] got;
        read_byte(got);
        check(tag, {24'h0, got}, {24'h0, exp_q.pop_front()});
    endtask

    task automatic bus_reset_chk(input string tag);
        int first;
        int lows;
        first = -1;
        lows  = 0;
        m_low = 1'b1;
        #(490 * US);
        m_low = 1'b0;
        for (int i = 1; i <= 200 * C; i++) begin
            #10;
            if (dq === 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
        end
        check_range({tag, "_pres_start"}, first, 30 * C, 30 * C + 4);
        check_range({tag, "_pres_width"}, lows, 120 * C - 2, 120 * C + 2);
    endtask

    task automatic read_scratch(input logic [15:0] t, input string tag);
        logic [7:0] sp [9];
        logic [7:0] c;
        logic [7:0] got;
        sp[0] = t[7:0];
        sp[1] = t[15:8];
        sp[2] = 8'h4B; sp[3] = 8'h46; sp[4] = 8'h7F;
        sp[5] = 8'hFF; sp[6] = 8'h0C; sp[7] = 8'h10;
        c = 8'h00;
        for (int i = 0; i < 8; i++) c = crc8(c, sp[i]);
        sp[8] = c;
        for (int i = 0; i < 9; i++) exp_q.push_back(sp[i]);
        c = 8'h00;
        for (int i = 0; i < 9; i++) begin
            read_byte(got);
            c = crc8(c, got);
            check($sformatf("%s_b%0d", tag, i), {24'h0, got}, {24'h0, exp_q.pop_front()});
        end
        check({tag, "_crc_all"}, {24'h0, c}, 32'h0);
    endtask

    initial begin
        longint conv_start;
        int     w;
        int     err_base;
        logic   b;

        #3;
        check("rst_dq", {31'h0, dq}, 32'h1);
        #(5 * US);
        sys_rst_n = 1'b1;
        #(2 * US);
        check("rst_dq_after", {31'h0, dq}, 32'h1);
        check("rst_conv_done", {31'h0, conv_done}, 32'h0);
        check("rst_cmd_err", {31'h0, cmd_err}, 32'h0);

        // Presence and power-on scratchpad
        bus_reset_chk("por");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_scratch(16'h0550, "por");

        // Convert T
        temp_in = 16'h0191;
        bus_reset_chk("conv");
        write_byte(8'hCC);
        write_byte(8'h44);
        conv_start = $time - 35 * US;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h00);
            read_bit(b);
            check("conv_busy_bit", {31'h0, b}, {24'h0, exp_q.pop_front()});
        end
        check("conv_done_early", conv_done_cnt, 0);
        w = 0;
        while (conv_done_cnt == 0 && w < 400 * C) begin
            #10;
            w++;
        end
        check("conv_done_seen", conv_done_cnt, 1);
        check_range("conv_time_us", int'((conv_done_t - conv_start) / US), CV - 2, CV + 6);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h01);
            read_bit(b);
            check("conv_idle_bit", {31'h0, b}, {24'h0, exp_q.pop_front()});
        end
        check("conv_done_once", conv_done_cnt, 1);
        bus_reset_chk("conv_rd");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_scratch(16'h0191, "conv");

        // Unsupported commands
        err_base = cmd_err_cnt;
        bus_reset_chk("bad_rom");
        write_byte(8'h33);
        check("bad_rom_err", cmd_err_cnt, err_base + 1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_check("bad_rom_z0");
        read_check("bad_rom_z1");
        bus_reset_chk("bad_func");
        write_byte(8'hCC);
        write_byte(8'hB4);
        check("bad_func_err", cmd_err_cnt, err_base + 2);

        // Bus reset in the middle of byte 3
        bus_reset_chk("mid");
        write_byte(8'hCC);
        write_byte(8'hBE);
        exp_q.push_back(8'h91);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h4B);
        read_check("mid_b0");
        read_check("mid_b1");
        read_check("mid_b2");
        for (int i = 0; i < 3; i++) read_bit(b);
        bus_reset_chk("mid_abort");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_scratch(16'h0191, "mid_restart");

        // Hard reset during presence
        m_low = 1'b1;
        #(490 * US);
        m_low = 1'b0;
        #(90 * US);
        check("hard_pres_low", {31'h0, dq}, 32'h0);
        sys_rst_n = 1'b0;
        #1;
        check("hard_dq_release", {31'h0, dq}, 32'h1);
        #(5 * US);
        sys_rst_n = 1'b1;
        #(300 * US);
        check("hard_dq_idle", {31'h0, dq}, 32'h1);
        exp_q.push_back(8'hFF);
        read_check("hard_idle_rd");
        bus_reset_chk("hard");
        write_byte(8'hCC);
        write_byte(8'hBE);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h05);
        read_check("hard_temp_lo");
        read_check("hard_temp_hi");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
